display_port_ctrl: RTL and testbench

- Port-mapped text-display controller between the kcpsm3 I/O bus and the character display memory (dsp).
- Holds cursor row/column and an attribute register, and writes {attr, char} cells at the cursor, with optional auto-advance and wrap.
- Runs a hardware clear-screen sequencer and exposes status and readback on in_port.
- Generalises the single-register row latch to parametrised geometry, attribute width and port base.

---
 rtl/display_pkg.sv | 31 +++
 rtl/display_cursor.sv | 53 +++++
 rtl/display_port_ctrl.sv | 177 +++++++++++++++++
 tb/tb_display_port_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM encoding and helpers for the display port controller
package display_pkg;

    // Port offsets within the 8-port block
    localparam logic [2:0] OFF_ROW  = 3'd0;
    localparam logic [2:0] OFF_COL  = 3'd1;
    localparam logic [2:0] OFF_ATTR = 3'd2;
    localparam logic [2:0] OFF_DATA = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;

    // CTRL register bit indices
    localparam int CTRL_CLEAR   = 0;
    localparam int CTRL_AUTOINC = 1;

    // STATUS readback bit indices
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVERRUN = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/display_cursor.sv
// rtl/display_cursor.sv - row/column cursor register with load, row-major advance and wrap
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   clr               force cursor to 0,0 (highest priority)
//   load_row, row_in  load row register
//   load_col, col_in  load column register
//   advance           step one cell in row-major order, wrapping at the last cell
//   row, col          current cursor position
module display_cursor #(
    parameter int ROW_W = 5,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load_row,
    input  logic [ROW_W-1:0] row_in,
    input  logic             load_col,
    input  logic [COL_W-1:0] col_in,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else begin
            if (load_row) begin
                row <= row_in;
            end
            if (load_col) begin
                col <= col_in;
            end
            // Loads and advance never coincide: they come from distinct port offsets.
            // Geometry is a power of two, so natural overflow gives the wrap.
            if (advance) begin
                if (&col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_port_ctrl.sv
// rtl/display_port_ctrl.sv - kcpsm3 port-mapped text display controller with cursor, attributes and hardware clear
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   port_id             CPU port address; block decodes on port_id[7:3] == BASE_PORT[7:3]
//   write_strobe        CPU write strobe (one cycle), data on out_port
//   read_strobe         CPU read strobe; a status read clears the sticky overrun flag
//   in_port             CPU read data (combinational from port_id)
//   dsp_en, dsp_wr      one-cycle display memory write pulse
//   dsp_row, dsp_col    cell address of the write
//   dsp_wr_data         {attr, char} written to the cell
//   busy                high on every cycle that carries a clear-step write
module display_port_ctrl
    import display_pkg::*;
#(
    parameter int         ROWS      = 32,
    parameter int         COLS      = 128,
    parameter int         ATTR_W    = 8,
    parameter int         CHAR_W    = 8,
    parameter logic [7:0] BASE_PORT = 8'h80,
    parameter logic [7:0] FILL_CHAR = 8'h20,
    localparam int        ROW_W     = clog2(ROWS),
    localparam int        COL_W     = clog2(COLS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               port_id,
    input  logic                     write_strobe,
    input  logic                     read_strobe,
    input  logic [7:0]               out_port,
    output logic [7:0]               in_port,
    output logic                     dsp_en,
    output logic                     dsp_wr,
    output logic [ROW_W-1:0]         dsp_row,
    output logic [COL_W-1:0]         dsp_col,
    output logic [ATTR_W+CHAR_W-1:0] dsp_wr_data,
    output logic                     busy
);

    state_t             state;
    logic [ATTR_W-1:0]  attr;
    logic               autoinc;
    logic               overrun;

    logic [ROW_W-1:0]   cur_row;
    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cnt_row;
    logic [COL_W-1:0]   cnt_col;

    logic               blk;
    logic               sel;
    logic [2:0]         off;
    logic               data_acc;
    logic               data_drop;
    logic               start;
    logic               step;
    logic               cnt_last;
    logic               stat_rd;

    assign blk      = (port_id[7:3] == BASE_PORT[7:3]);
    assign sel      = write_strobe & blk;
    assign off      = port_id[2:0];
    assign stat_rd  = read_strobe & blk & (off == OFF_CTRL);

    // busy covers every clear pulse, including the final one emitted after the
    // FSM has already returned to IDLE, so it is the guard for clear-in-progress.
    assign data_acc  = sel & (off == OFF_DATA) & ~busy;
    assign data_drop = sel & (off == OFF_DATA) & busy;
    assign start     = sel & (off == OFF_CTRL) & out_port[CTRL_CLEAR] & ~busy & (state == ST_IDLE);

    // The clear counter rests at 0,0 in IDLE (it wraps after the last cell), so the
    // starting edge can already emit cell 0,0 and keep the 1-cycle write latency.
    assign step     = start | (state == ST_CLEAR);
    assign cnt_last = (&cnt_row) & (&cnt_col);

    assign dsp_wr   = dsp_en;

    display_cursor #(.ROW_W(ROW_W), .COL_W(COL_W)) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .clr      (step & cnt_last),
        .load_row (sel & (off == OFF_ROW)),
        .row_in   (out_port[ROW_W-1:0]),
        .load_col (sel & (off == OFF_COL)),
        .col_in   (out_port[COL_W-1:0]),
        .advance  (data_acc & autoinc),
        .row      (cur_row),
        .col      (cur_col)
    );

    display_cursor #(.ROW_W(ROW_W), .COL_W(COL_W)) u_clear_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .load_row (1'b0),
        .row_in   ('0),
        .load_col (1'b0),
        .col_in   ('0),
        .advance  (step),
        .row      (cnt_row),
        .col      (cnt_col)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            attr        <= '0;
            autoinc     <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            dsp_en      <= 1'b0;
            dsp_row     <= '0;
            dsp_col     <= '0;
            dsp_wr_data <= '0;
        end else begin
            dsp_en <= 1'b0;
            busy   <= step;

            if (sel && (off == OFF_ATTR)) begin
                attr <= out_port[ATTR_W-1:0];
            end
            if (sel && (off == OFF_CTRL)) begin
                autoinc <= out_port[CTRL_AUTOINC];
            end

            // A fresh overrun outranks the read-clear on the same edge.
            if (data_drop) begin
                overrun <= 1'b1;
            end else if (stat_rd) begin
                overrun <= 1'b0;
            end

            if (step) begin
                dsp_en      <= 1'b1;
                dsp_row     <= cnt_row;
                dsp_col     <= cnt_col;
                dsp_wr_data <= {attr, FILL_CHAR[CHAR_W-1:0]};
            end else if (data_acc) begin
                dsp_en      <= 1'b1;
                dsp_row     <= cur_row;
                dsp_col     <= cur_col;
                dsp_wr_data <= {attr, out_port[CHAR_W-1:0]};
            end

            case (state)
                ST_IDLE: begin
                    if (start && !cnt_last) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (blk) begin
            case (off)
                OFF_ROW:  in_port = 8'(cur_row);
                OFF_COL:  in_port = 8'(cur_col);
                OFF_ATTR: in_port = 8'(attr);
                OFF_CTRL: begin
                    in_port[STAT_BUSY]    = busy;
                    in_port[STAT_OVERRUN] = overrun;
                end
                default:  in_port = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_display_port_ctrl.sv
// tb/tb_display_port_ctrl.sv - scoreboard testbench for display_port_ctrl
module tb_display_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic        dsp_en;
    logic        dsp_wr;
    logic [4:0]  dsp_row;
    logic [6:0]  dsp_col;
    logic [15:0] dsp_wr_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [6:0]  c;
        logic [15:0] d;
        logic        b;
    } exp_t;

    exp_t q[$];

    display_port_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .dsp_en       (dsp_en),
        .dsp_wr       (dsp_wr),
        .dsp_row      (dsp_row),
        .dsp_col      (dsp_col),
        .dsp_wr_data  (dsp_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every display write must match the next expected cell.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (reset && dsp_en) begin
            a = {dsp_row, dsp_col, dsp_wr_data, busy};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL dsp_unexpected got row=%0d col=%0d data=%h busy=%b want none",
                         dsp_row, dsp_col, dsp_wr_data, busy);
            end else begin
                e = q.pop_front();
                if (a !== e || dsp_wr !== 1'b1) begin
                    bad++;
                    $display("FAIL dsp_write got row=%0d col=%0d data=%h busy=%b wr=%b want row=%0d col=%0d data=%h busy=%b wr=1",
                             dsp_row, dsp_col, dsp_wr_data, busy, dsp_wr, e.r, e.c, e.d, e.b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        @(posedge clk); #1;
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic rd(input string name, input logic [7:0] p, input logic [7:0] e);
        port_id = p;
        #1;
        chk(name, in_port, e);
        port_id = 8'h00;
    endtask

    task automatic push(input logic [4:0] r, input logic [6:0] c, input logic [15:0] d, input logic b);
        exp_t e;
        e = {r, c, d, b};
        q.push_back(e);
    endtask

    task automatic push_clear(input logic [7:0] a);
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] k;
            k = i[11:0];
            push(k[11:7], k[6:0], {a, 8'h20}, 1'b1);
        end
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, (n < 6000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        reset        = 1'b0;
        port_id      = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        out_port     = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dsp_en", dsp_en, 0);
        chk("rst_busy", busy, 0);
        rd("rst_row", 8'h80, 8'h00);
        rd("rst_status", 8'h84, 8'h00);
        reset = 1'b1;

        // Reset in the middle of a clear aborts it
        wr(8'h82, 8'h07);
        push_clear(8'h07);
        wr(8'h84, 8'h01);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        @(posedge clk); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_dsp_en", dsp_en, 0);
        reset = 1'b1;
        rd("midrst_status", 8'h84, 8'h00);
        rd("midrst_attr", 8'h82, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_busy_later", busy, 0);

        // Addressed write, no autoinc
        wr(8'h80, 8'd3);
        wr(8'h81, 8'd5);
        wr(8'h82, 8'h0F);
        push(5'd3, 7'd5, 16'h0F41, 1'b0);
        wr(8'h83, 8'h41);
        rd("noinc_row", 8'h80, 8'd3);
        rd("noinc_col", 8'h81, 8'd5);
        rd("attr_rb", 8'h82, 8'h0F);

        // Autoinc: full wrap, row step, plain column step
        wr(8'h84, 8'h02);
        wr(8'h80, 8'd31);
        wr(8'h81, 8'd127);
        push(5'd31, 7'd127, 16'h0F42, 1'b0);
        wr(8'h83, 8'h42);
        rd("wrap_row", 8'h80, 8'd0);
        rd("wrap_col", 8'h81, 8'd0);
        wr(8'h80, 8'd2);
        wr(8'h81, 8'd127);
        push(5'd2, 7'd127, 16'h0F43, 1'b0);
        wr(8'h83, 8'h43);
        rd("rowstep_row", 8'h80, 8'd3);
        rd("rowstep_col", 8'h81, 8'd0);
        push(5'd3, 7'd0, 16'h0F44, 1'b0);
        wr(8'h83, 8'h44);
        rd("colstep_col", 8'h81, 8'd1);

        // Full clear with overrun and mid-clear row write
        wr(8'h82, 8'h07);
        push_clear(8'h07);
        wr(8'h84, 8'h01);
        rd("clr_status_busy", 8'h84, 8'h01);
        wr(8'h83, 8'h55);
        rd("clr_status_ovr", 8'h84, 8'h03);
        wr(8'h80, 8'd9);
        rd("clr_mid_row", 8'h80, 8'd9);
        wait_clear_done("clr_done_timeout");
        rd("clr_end_row", 8'h80, 8'd0);
        rd("clr_end_col", 8'h81, 8'd0);
        @(posedge clk); #1;
        port_id     = 8'h84;
        read_strobe = 1'b1;
        #1;
        chk("ovr_sticky", in_port, 8'h02);
        @(posedge clk); #1;
        read_strobe = 1'b0;
        chk("ovr_cleared", in_port, 8'h00);
        port_id = 8'h00;

        // Decode: other block, unused offset, DATA offset in wrong block
        wr(8'h88, 8'd5);
        wr(8'h85, 8'd9);
        wr(8'h03, 8'h41);
        rd("dec_row", 8'h80, 8'd0);
        rd("dec_col", 8'h81, 8'd0);
        rd("dec_attr", 8'h82, 8'h07);
        @(posedge clk); #1;
        rd("dec_off7", 8'h87, 8'h00);
        rd("dec_other_blk", 8'h88, 8'h00);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
